// File: rtl/fetch_branch_ctrl.sv
// fetch_branch_ctrl: instruction-fetch and next-PC controller.
// Fetches the word at PC over a req/ack handshake and holds it until the
// pipeline consumes it. In the consume cycle it decodes beq/bne/j/jal and
// drives PcSel/Address/PcStep back into the PC register unit.
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a REQ phase
// that waits TIMEOUT_CYCLES without ImemAck parks the controller in ERR and
// raises a sticky FetchErr.
module fetch_branch_ctrl #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          TMO_W          = 7,
    parameter logic [31:0] INSTR_RESET    = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        PcReSet,
    input  logic [31:0] PC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        Stall,
    input  logic        CmpEq,
    output logic [1:0]  PcSel,
    output logic [31:0] Address,
    output logic        PcStep,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q, req_d;
    logic        consume_s;
    logic        ack_take_s;
    logic [5:0]  op_s;
    logic [3:0]  jmp_region_s;
    logic [27:0] unused_pc_low_s;
    logic [1:0]  pc_sel_s;
    logic [31:0] address_s;

`ifdef FETCH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`else
    localparam int unused_tmo_cfg = TIMEOUT_CYCLES + TMO_W;
`endif

    // req_q is low in the first cycle after reset release, so an ack that
    // straddles the reset is never taken as the answer to a new request.
    assign consume_s  = (state_q == ST_HOLD) && !Stall;
    assign ack_take_s = (state_q == ST_REQ) && req_q && ImemAck;
    assign op_s       = instr_q[31:26];
    assign {jmp_region_s, unused_pc_low_s} = PC + 32'd4;

    // Next-state, held-instruction and timeout bookkeeping.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_REQ: begin
                if (ack_take_s) begin
                    instr_d = ImemData;
                    state_d = ST_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (req_q) begin
                    if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
`endif
                else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!Stall) begin
                    // PC updates on this same edge, so the next request
                    // naturally carries the new PC.
                    state_d = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
                    tmo_d   = {TMO_W{1'b0}};
`endif
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
        req_d = (state_d == ST_REQ);
    end

    // State, held instruction and request flop; reset abandons any fetch.
    always_ff @(posedge Clk or posedge PcReSet) begin
        if (PcReSet) begin
            state_q <= ST_REQ;
            instr_q <= INSTR_RESET;
            req_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= {TMO_W{1'b0}};
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            req_q   <= req_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    // Branch/jump decode; only meaningful in the consume cycle.
    always_comb begin
        pc_sel_s  = 2'b00;
        address_s = 32'h0000_0000;
        if (consume_s) begin
            case (op_s)
                OP_BEQ: begin
                    pc_sel_s  = CmpEq ? 2'b01 : 2'b00;
                    address_s = {{16{instr_q[15]}}, instr_q[15:0]};
                end
                OP_BNE: begin
                    pc_sel_s  = CmpEq ? 2'b00 : 2'b01;
                    address_s = {{16{instr_q[15]}}, instr_q[15:0]};
                end
                OP_J, OP_JAL: begin
                    pc_sel_s  = 2'b10;
                    address_s = {jmp_region_s, instr_q[25:0], 2'b00};
                end
                default: begin
                    pc_sel_s  = 2'b00;
                    address_s = 32'h0000_0000;
                end
            endcase
        end else begin
            pc_sel_s  = 2'b00;
            address_s = 32'h0000_0000;
        end
    end

    assign ImemReq    = req_q;
    assign ImemAddr   = PC;
    assign Instr      = instr_q;
    assign InstrValid = (state_q == ST_HOLD);
    assign PcSel      = pc_sel_s;
    assign Address    = address_s;
    assign PcStep     = consume_s;
`ifdef FETCH_TIMEOUT_EN
    assign FetchErr   = err_q;
`else
    assign FetchErr   = 1'b0;
`endif

endmodule
